// File: rtl/hc04_self_test_ctrl_pkg.sv
// Shared definitions for the inverter-array self-test sequencer: FSM encodings
// and the generator for the fixed test-vector set.
package hc04_self_test_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Vector k of the 2n+2 set: all-0, all-1, one-hot walk, one-cold walk.
   // Returned 32 bits wide; callers truncate to their gate count (n < 32).
   function automatic logic [31:0] vec_of(input int unsigned k, input int unsigned n);
      logic [31:0] all_ones;
      logic [31:0] v;
      all_ones = (32'd1 << n) - 32'd1;
      if (k == 0) begin
         v = '0;
      end else if (k == 1) begin
         v = all_ones;
      end else if (k < n + 2) begin
         v = 32'd1 << (k - 2);
      end else begin
         v = all_ones & ~(32'd1 << (k - n - 2));
      end
      return v;
   endfunction

endpackage

// File: rtl/hc04_self_test_ctrl_bit_sync2.sv
// Multi-bit two-flop synchronizer for the asynchronous inverter outputs.
// Bits are synchronized independently; the sequencer only samples them after settling.
module bit_sync2 #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/hc04_self_test_ctrl.sv
// Self-test sequencer for an N-gate inverter array: walks the vector set, waits a
// settle interval per vector, and accumulates a sticky per-gate fail mask.
module hc04_self_test_ctrl
   import hc04_self_test_ctrl_pkg::*;
#(
   parameter int N_GATES    = 6,
   parameter int SETTLE_CYC = 4,
   parameter int IDX_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_GATES-1:0] y_obs,
   output logic [N_GATES-1:0] a_drv,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [N_GATES-1:0] fail_mask,
   output logic [IDX_W-1:0]   vec_idx
);

   localparam int K     = 2 * N_GATES + 2;
   localparam int CNT_W = $clog2(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(K - 1);

   // Handshake: start is a level request sampled only in IDLE; once accepted, busy is
   // high until the DONE cycle, where done pulses for exactly one cycle and busy is low.
   // start seen while busy is ignored; start still high in DONE launches a new run
   // on the edge after returning to IDLE.

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     vec_idx_q, vec_idx_d;
   logic [N_GATES-1:0]   a_drv_q, a_drv_d;
   logic [N_GATES-1:0]   fail_mask_q, fail_mask_d;
   logic                 pass_q, pass_d;
   logic [N_GATES-1:0]   y_sync;
   logic [N_GATES-1:0]   first_vec;
   logic [N_GATES-1:0]   next_vec;
   logic                 last_vec;

   bit_sync2 #(.W(N_GATES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (y_obs),
      .q   (y_sync)
   );

   assign first_vec = N_GATES'(vec_of(32'd0, N_GATES));
   assign next_vec  = N_GATES'(vec_of(32'(vec_idx_q) + 32'd1, N_GATES));
   assign last_vec  = (vec_idx_q == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         vec_idx_q   <= '0;
         a_drv_q     <= '0;
         fail_mask_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vec_idx_q   <= vec_idx_d;
         a_drv_q     <= a_drv_d;
         fail_mask_q <= fail_mask_d;
         pass_q      <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == '0) state_d = ST_CHECK;
         ST_CHECK:  state_d = last_vec ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      vec_idx_d   = vec_idx_q;
      a_drv_d     = a_drv_q;
      fail_mask_d = fail_mask_q;
      pass_d      = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               fail_mask_d = '0;
               pass_d      = 1'b0;
               vec_idx_d   = '0;
               a_drv_d     = first_vec;
               cnt_d       = CNT_RELOAD;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end
         ST_CHECK: begin
            // A healthy gate reads back the inverse of what is driven.
            fail_mask_d = fail_mask_q | (y_sync ^ ~a_drv_q);
            if (!last_vec) begin
               vec_idx_d = vec_idx_q + 1'b1;
               a_drv_d   = next_vec;
               cnt_d     = CNT_RELOAD;
            end
         end
         ST_DONE: begin
            pass_d = (fail_mask_q == '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_SETTLE, ST_CHECK: busy = 1'b1;
         ST_DONE:             done = 1'b1;
         default:             ;
      endcase
   end

   assign a_drv     = a_drv_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_hc04_self_test_ctrl.sv
// Bench for hc04_self_test_ctrl: inverter-array model with fault hooks and a
// scoreboard of expected {pass, fail_mask} per run.
module tb_hc04_self_test_ctrl;

   localparam int N = 6;
   localparam int W = N + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, start8;
   logic [N-1:0] y_obs, y_obs8;
   logic [N-1:0] a_drv, a_drv8;
   logic         busy, busy8, done, done8, pass, pass8;
   logic [N-1:0] fail_mask, fail_mask8;
   logic [3:0]   vec_idx, vec_idx8;

   logic [W-1:0] exp_q[$];
   logic [N-1:0] vec_q[$];

   int cmp_cnt = 0;
   int err_cnt = 0;

   // inverter-array model state and fault hooks
   logic [N-1:0] hist  [0:7];
   logic [N-1:0] hist8 [0:7];
   int           dly     = 1;
   logic [N-1:0] stuck1  = '0;
   logic         short12 = 1'b0;
   logic [N-1:0] y_raw;

   // clock / reset
   always #5 clk = ~clk;

   hc04_self_test_ctrl #(.N_GATES(N), .SETTLE_CYC(4), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .y_obs(y_obs), .a_drv(a_drv),
      .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask), .vec_idx(vec_idx)
   );

   hc04_self_test_ctrl #(.N_GATES(N), .SETTLE_CYC(8), .IDX_W(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .y_obs(y_obs8), .a_drv(a_drv8),
      .busy(busy8), .done(done8), .pass(pass8), .fail_mask(fail_mask8), .vec_idx(vec_idx8)
   );

   always @(posedge clk) begin
      hist[0]  <= ~a_drv;
      hist8[0] <= ~a_drv8;
      for (int i = 1; i < 8; i++) begin
         hist[i]  <= hist[i-1];
         hist8[i] <= hist8[i-1];
      end
   end

   always_comb begin
      y_raw = hist[dly-1];
      y_obs = y_raw;
      if (short12) begin
         y_obs[1] = y_raw[1] & y_raw[2];
         y_obs[2] = y_raw[1] & y_raw[2];
      end
      y_obs = y_obs | stuck1;
   end

   assign y_obs8 = hist8[4];

   function automatic logic [N-1:0] exp_vec(input int k);
      logic [N-1:0] v;
      v = '0;
      if (k == 1) v = '1;
      else if (k >= 2 && k < N + 2) v[k-2] = 1'b1;
      else if (k >= N + 2) begin
         v = '1;
         v[k-N-2] = 1'b0;
      end
      return v;
   endfunction

   // driver: pulse start for one cycle, return cycles from accepting edge to done
   task automatic launch(output int n);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done) n = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; start8 = 1'b0;
      repeat (10) @(negedge clk);
      cmp_cnt++;
      if ({a_drv, busy, done, pass, fail_mask, vec_idx} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got a_drv=%b busy=%b done=%b pass=%b mask=%b idx=%0d required all zero",
                  a_drv, busy, done, pass, fail_mask, vec_idx);
      end
      cmp_cnt++;
      if ({a_drv8, busy8, done8, pass8, fail_mask8, vec_idx8} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs8: got a_drv=%b busy=%b done=%b required zero", a_drv8, busy8, done8);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_array;
      int n, last, kexp;
      logic [N-1:0] ev;
      logic [W-1:0] er;
      exp_q.push_back({1'b1, {N{1'b0}}});
      for (int k = 0; k < 2 * N + 2; k++) vec_q.push_back(exp_vec(k));
      last = -1; kexp = 0; n = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (busy && int'(vec_idx) != last) begin
            last = int'(vec_idx);
            ev = (vec_q.size() != 0) ? vec_q.pop_front() : 'x;
            cmp_cnt++;
            if ({vec_idx, a_drv} !== {4'(kexp), ev}) begin
               err_cnt++;
               $display("FAIL vector_walk: got idx=%0d a_drv=%b required idx=%0d a_drv=%b", vec_idx, a_drv, kexp, ev);
            end
            kexp++;
         end
         if (done) break;
      end
      cmp_cnt++;
      if (n !== 71 || !done) begin
         err_cnt++;
         $display("FAIL good_latency: got %0d cycles required 71", n);
      end
      cmp_cnt++;
      if (vec_q.size() != 0) begin
         err_cnt++;
         $display("FAIL good_vector_count: %0d vectors not driven required 0", vec_q.size());
      end
      @(negedge clk);
      cmp_cnt++;
      if (done !== 1'b0) begin
         err_cnt++;
         $display("FAIL done_one_cycle: got done=%b required 0", done);
      end
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask} !== er) begin
         err_cnt++;
         $display("FAIL good_result: got pass=%b mask=%b required %b", pass, fail_mask, er);
      end
      repeat (5) @(negedge clk);
      cmp_cnt++;
      if ({a_drv, pass, fail_mask, busy} !== {6'b011111, 1'b1, 6'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL hold_after_done: got a_drv=%b pass=%b mask=%b busy=%b required 011111 1 000000 0",
                  a_drv, pass, fail_mask, busy);
      end
   endtask

   task automatic test_stuck_at_1;
      int n;
      bit seen1, seen2;
      logic [W-1:0] er;
      stuck1 = 6'b001000;
      exp_q.push_back({1'b0, 6'b001000});
      seen1 = 0; seen2 = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 300 && !done) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (busy && vec_idx == 4'd1 && !seen1) begin
            seen1 = 1;
            cmp_cnt++;
            if (fail_mask !== 6'b000000) begin
               err_cnt++;
               $display("FAIL stuck_before_k1: got mask=%b required 000000", fail_mask);
            end
         end
         if (busy && vec_idx == 4'd2 && !seen2) begin
            seen2 = 1;
            cmp_cnt++;
            if (fail_mask !== 6'b001000) begin
               err_cnt++;
               $display("FAIL stuck_after_k1: got mask=%b required 001000", fail_mask);
            end
         end
      end
      cmp_cnt++;
      if (n !== 71 || !done) begin
         err_cnt++;
         $display("FAIL stuck_latency: got %0d cycles required 71", n);
      end
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask} !== er) begin
         err_cnt++;
         $display("FAIL stuck_result: got pass=%b mask=%b required %b", pass, fail_mask, er);
      end
      stuck1 = '0;
   endtask

   task automatic test_short;
      int n;
      logic [W-1:0] er;
      short12 = 1'b1;
      exp_q.push_back({1'b0, 6'b000110});
      launch(n);
      cmp_cnt++;
      if (n !== 71) begin
         err_cnt++;
         $display("FAIL short_latency: got %0d cycles required 71", n);
      end
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask} !== er) begin
         err_cnt++;
         $display("FAIL short_result: got pass=%b mask=%b required %b", pass, fail_mask, er);
      end
      short12 = 1'b0;
   endtask

   task automatic test_slow_array;
      int n;
      dly = 5;
      repeat (8) @(negedge clk);
      launch(n);
      cmp_cnt++;
      if (n !== 71) begin
         err_cnt++;
         $display("FAIL slow_latency: got %0d cycles required 71", n);
      end
      @(negedge clk);
      cmp_cnt++;
      if (pass !== 1'b0 || fail_mask === 6'b000000) begin
         err_cnt++;
         $display("FAIL slow_settle4: got pass=%b mask=%b required pass=0 mask nonzero", pass, fail_mask);
      end
      dly = 1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_settle8;
      int n;
      logic [W-1:0] er;
      exp_q.push_back({1'b1, 6'b000000});
      @(negedge clk);
      start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 400) begin
         @(negedge clk);
         n++;
      end
      cmp_cnt++;
      if (n !== 127 || !done8) begin
         err_cnt++;
         $display("FAIL settle8_latency: got %0d cycles required 127", n);
      end
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass8, fail_mask8} !== er) begin
         err_cnt++;
         $display("FAIL settle8_result: got pass=%b mask=%b required %b", pass8, fail_mask8, er);
      end
   endtask

   task automatic test_repulse;
      int n;
      bit pulsed;
      logic [W-1:0] er;
      exp_q.push_back({1'b1, 6'b000000});
      pulsed = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 300 && !done) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (vec_idx == 4'd5 && !pulsed) begin
            pulsed = 1;
            start = 1'b1;
         end
      end
      start = 1'b0;
      cmp_cnt++;
      if (n !== 71 || !done) begin
         err_cnt++;
         $display("FAIL repulse_latency: got %0d cycles required 71", n);
      end
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask, busy} !== {er, 1'b0}) begin
         err_cnt++;
         $display("FAIL repulse_result: got pass=%b mask=%b busy=%b required %b busy=0", pass, fail_mask, busy, er);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      logic [W-1:0] er;
      stuck1 = 6'b001000;
      exp_q.push_back({1'b0, 6'b001000});
      exp_q.push_back({1'b1, 6'b000000});
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 300 && !done) begin
         @(negedge clk);
         n++;
      end
      cmp_cnt++;
      if (n !== 71 || !done) begin
         err_cnt++;
         $display("FAIL b2b_first_latency: got %0d cycles required 71", n);
      end
      stuck1 = '0;
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask} !== er) begin
         err_cnt++;
         $display("FAIL b2b_first_result: got pass=%b mask=%b required %b", pass, fail_mask, er);
      end
      @(negedge clk);
      cmp_cnt++;
      if ({busy, pass, fail_mask} !== {1'b1, 1'b0, 6'b000000}) begin
         err_cnt++;
         $display("FAIL b2b_restart_clear: got busy=%b pass=%b mask=%b required 1 0 000000", busy, pass, fail_mask);
      end
      n = 1;
      while (n < 300 && !done) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      cmp_cnt++;
      if (n !== 71 || !done) begin
         err_cnt++;
         $display("FAIL b2b_second_latency: got %0d cycles required 71", n);
      end
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask} !== er) begin
         err_cnt++;
         $display("FAIL b2b_second_result: got pass=%b mask=%b required %b", pass, fail_mask, er);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      int n;
      bit seen_done;
      logic [W-1:0] er;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 300 && vec_idx != 4'd6) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      cmp_cnt++;
      if ({a_drv, busy, done, vec_idx, fail_mask, pass} !== '0) begin
         err_cnt++;
         $display("FAIL reset_mid_run: got a_drv=%b busy=%b done=%b idx=%0d mask=%b required all zero",
                  a_drv, busy, done, vec_idx, fail_mask);
      end
      seen_done = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      cmp_cnt++;
      if (seen_done !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_no_done: got done pulse required none");
      end
      exp_q.push_back({1'b1, 6'b000000});
      launch(n);
      cmp_cnt++;
      if (n !== 71) begin
         err_cnt++;
         $display("FAIL after_reset_latency: got %0d cycles required 71", n);
      end
      @(negedge clk);
      er = exp_q.pop_front();
      cmp_cnt++;
      if ({pass, fail_mask} !== er) begin
         err_cnt++;
         $display("FAIL after_reset_result: got pass=%b mask=%b required %b", pass, fail_mask, er);
      end
   endtask

   initial begin
      test_reset;
      test_good_array;
      test_stuck_at_1;
      test_short;
      test_slow_array;
      test_settle8;
      test_repulse;
      test_back_to_back;
      test_reset_mid_run;
      cmp_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL scoreboard_drain: %0d expected results unconsumed required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
